seq_divider: RTL and testbench

- Shared sequential unsigned restoring divider for the bike computer datapath; sits directly downstream of the average-speed stage.
- Consumes its dividend/divisor and returns quotient with Busy/Ready status.
- Top level drives start. Computes one quotient bit per clock, so area stays small for a low-rate display path.

---
 rtl/bike_pkg.sv | 13 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// Shared definitions for the bike computer datapath: divider width and
// divider FSM state encoding.
package bike_pkg;

  localparam int unsigned WIDTH_DIV = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the divider and the stage that drives it.
interface seq_divider_if #(
  parameter int unsigned WIDTH = bike_pkg::WIDTH_DIV
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             ready;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, ready, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, ready, div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Fixed latency: WIDTH iterations regardless of operands, including divisor 0.
module seq_divider
  import bike_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DIV,
  parameter int unsigned CNT_W = 5
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  state_t state, state_next;

  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH-1:0]     r_reg;
  logic [WIDTH-1:0]     d_reg;
  logic [CNT_W-1:0]     cnt;
  logic                 dz_reg;
  logic [WIDTH-1:0]     quotient_reg;
  logic [WIDTH-1:0]     remainder_reg;
  logic                 busy_reg;
  logic                 ready_reg;
  logic                 div_by_zero_reg;

  logic                 load_c;
  logic                 last_c;
  logic [2*WIDTH-1:0]   step_c;

  // One restoring step: shift {R,Q} left, subtract D when it fits.
  // The borrow out of the (WIDTH+1)-bit subtraction is the "R < D" flag.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_new;
    r_sh  = {r, q[WIDTH-1]};
    diff  = r_sh - {1'b0, d};
    r_new = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    return {r_new, q[WIDTH-2:0], ~diff[WIDTH]};
  endfunction

  assign step_c = div_step(r_reg, q_reg, d_reg);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_RUN;
          load_c     = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_next = ST_DONE;
          last_c     = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_next = ST_RUN;
          load_c     = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Working registers and registered results
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg           <= '0;
      r_reg           <= '0;
      d_reg           <= '0;
      cnt             <= '0;
      dz_reg          <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      busy_reg        <= 1'b0;
      ready_reg       <= 1'b0;
      div_by_zero_reg <= 1'b0;
    end else begin
      busy_reg  <= (state_next == ST_RUN);
      ready_reg <= (state_next == ST_DONE);
      if (load_c) begin
        q_reg  <= bus.dividend;
        d_reg  <= bus.divisor;
        r_reg  <= '0;
        cnt    <= CNT_W'(WIDTH);
        dz_reg <= (bus.divisor == '0);
      end else if (state == ST_RUN) begin
        r_reg <= step_c[2*WIDTH-1:WIDTH];
        q_reg <= step_c[WIDTH-1:0];
        cnt   <= cnt - CNT_W'(1);
        if (last_c) begin
          // With D=0 every step subtracts nothing, so R ends holding the dividend.
          quotient_reg    <= dz_reg ? '1 : step_c[WIDTH-1:0];
          remainder_reg   <= step_c[2*WIDTH-1:WIDTH];
          div_by_zero_reg <= dz_reg;
        end
      end
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.busy        = busy_reg;
  assign bus.ready       = ready_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, extremes, divide-by-zero,
// start during RUN/DONE and reset mid-operation.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  seq_divider_if #(.WIDTH(16)) bus ();

  seq_divider #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called just after the acceptance edge; follows the fixed 16-cycle run.
  task automatic wait_result(input string tag, input logic [15:0] eq, input logic [15:0] er,
                             input logic edz, input logic [15:0] prev_q);
    logic busy_ok;
    logic hold_ok;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!(bus.busy === 1'b1 && bus.ready === 1'b0)) busy_ok = 1'b0;
      if (bus.quotient !== prev_q) hold_ok = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_busy16"}, 32'(busy_ok), 32'd1);
    chk({tag, "_hold"},   32'(hold_ok), 32'd1);
    chk({tag, "_ready"},  32'(bus.ready), 32'd1);
    chk({tag, "_nobusy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_q"},      32'(bus.quotient), 32'(eq));
    chk({tag, "_r"},      32'(bus.remainder), 32'(er));
    chk({tag, "_dz"},     32'(bus.div_by_zero), 32'(edz));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edz,
                        input logic [15:0] prev_q);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'hDEAD;
    bus.divisor  = 16'h0003;
    wait_result(tag, eq, er, edz, prev_q);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse1"}, 32'(bus.ready), 32'd0);
  endtask

  initial begin
    logic ready_seen;
    total        = 0;
    passed       = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q",    32'(bus.quotient), 32'd0);
    chk("rst_r",    32'(bus.remainder), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdy",  32'(bus.ready), 32'd0);
    chk("rst_dz",   32'(bus.div_by_zero), 32'd0);
    rst = 1'b1;

    // 1000/7 with start held and new operands during RUN, then accepted in DONE
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd7;
    @(posedge clk);
    #1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd9;
    wait_result("d1000_7", 16'd142, 16'd6, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'hBEEF;
    bus.divisor  = 16'd1;
    wait_result("d100_9", 16'd11, 16'd1, 1'b0, 16'd142);
    @(posedge clk);
    @(negedge clk);
    chk("d100_9_pulse1", 32'(bus.ready), 32'd0);
    chk("d100_9_idle",   32'(bus.busy), 32'd0);

    run_op("d65535_1", 16'd65535, 16'd1,  16'd65535, 16'd0, 1'b0, 16'd11);
    run_op("d3_10",    16'd3,     16'd10, 16'd0,     16'd3, 1'b0, 16'd65535);
    run_op("d5_0",     16'd5,     16'd0,  16'hFFFF,  16'd5, 1'b1, 16'd0);
    run_op("d20_4",    16'd20,    16'd4,  16'd5,     16'd0, 1'b0, 16'hFFFF);

    // Reset asserted in the 8th RUN cycle aborts the operation
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor  = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("abort_busy8", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_q",    32'(bus.quotient), 32'd0);
    chk("abort_r",    32'(bus.remainder), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rdy",  32'(bus.ready), 32'd0);
    chk("abort_dz",   32'(bus.div_by_zero), 32'd0);
    rst = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.busy !== 1'b0) ready_seen = 1'b1;
    end
    chk("abort_quiet", 32'(ready_seen), 32'd0);

    run_op("d81_9", 16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
